// File: rtl/crank_wheel_gen.sv
// Missing-tooth crank trigger-wheel generator: emits tooth_cnt positions per revolution,
// the last teeth_missing of which stay low, with a one-cycle strobe at the start of tooth 0.
module crank_wheel_gen #(
    parameter int PERIOD_W = 32,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic [CNT_W-1:0]    tooth_cnt,
    input  logic [CNT_W-1:0]    teeth_missing,
    input  logic [PERIOD_W-1:0] tooth_period,
    output logic                vr_out,
    output logic                rev_strobe,
    output logic [CNT_W-1:0]    tooth_idx,
    output logic                running,
    output logic                cfg_err,
    output logic [1:0]          state_dbg
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [PERIOD_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    miss_q, miss_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic                vr_q, vr_d;
    logic                strobe_q, strobe_d;
    logic                run_q, run_d;
    logic                err_q, err_d;

    logic                in_valid;
    logic [PERIOD_W-1:0] in_hi;
    logic [PERIOD_W-1:0] sh_hi;
    logic [PERIOD_W-1:0] sh_lo;
    logic                pc_zero;
    logic                last_pos;
    logic [CNT_W-1:0]    nxt_idx;
    logic                nxt_missing;
    logic                take_sample;

    // Live inputs are only ever looked at here, at a sample point.
    assign in_valid = (tooth_cnt >= CNT_W'(2)) &&
                      (teeth_missing < tooth_cnt) &&
                      (tooth_period >= PERIOD_W'(2));
    assign in_hi    = tooth_period >> 1;

    assign sh_hi       = per_q >> 1;
    assign sh_lo       = per_q - sh_hi;
    assign pc_zero     = (pc_q == '0);
    assign last_pos    = (idx_q == cnt_q - CNT_W'(1));
    assign nxt_idx     = idx_q + CNT_W'(1);
    assign nxt_missing = (nxt_idx >= cnt_q - miss_q);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        miss_d      = miss_q;
        per_d       = per_q;
        err_d       = err_q;
        strobe_d    = 1'b0;
        take_sample = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            pc_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: take_sample = 1'b1;
                ST_HIGH: begin
                    if (pc_zero) begin
                        state_d = ST_LOW;
                        pc_d    = sh_lo - PERIOD_W'(1);
                    end else begin
                        pc_d = pc_q - PERIOD_W'(1);
                    end
                end
                ST_LOW, ST_GAP: begin
                    if (!pc_zero) begin
                        pc_d = pc_q - PERIOD_W'(1);
                    end else if (last_pos) begin
                        take_sample = 1'b1;
                    end else begin
                        idx_d = nxt_idx;
                        if (nxt_missing) begin
                            state_d = ST_GAP;
                            pc_d    = per_q - PERIOD_W'(1);
                        end else begin
                            state_d = ST_HIGH;
                            pc_d    = sh_hi - PERIOD_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Start-up and every wrap share one path: tooth 0 is never a missing position.
        if (take_sample) begin
            idx_d = '0;
            if (in_valid) begin
                state_d  = ST_HIGH;
                pc_d     = in_hi - PERIOD_W'(1);
                cnt_d    = tooth_cnt;
                miss_d   = teeth_missing;
                per_d    = tooth_period;
                strobe_d = 1'b1;
                err_d    = 1'b0;
            end else begin
                state_d = ST_IDLE;
                pc_d    = '0;
                err_d   = 1'b1;
            end
        end
    end

    assign vr_d  = (state_d == ST_HIGH);
    assign run_d = (state_d != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            miss_q   <= '0;
            per_q    <= '0;
            vr_q     <= 1'b0;
            strobe_q <= 1'b0;
            run_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            miss_q   <= miss_d;
            per_q    <= per_d;
            vr_q     <= vr_d;
            strobe_q <= strobe_d;
            run_q    <= run_d;
            err_q    <= err_d;
        end
    end

    assign vr_out     = vr_q;
    assign rev_strobe = strobe_q;
    assign tooth_idx  = idx_q;
    assign running    = run_q;
    assign cfg_err    = err_q;
    assign state_dbg  = state_q;

endmodule
